ppl_ctrl: RTL and testbench

Parametrised pipeline controller that supersedes the single-bit hold controller. It generates a per-stage hold/flush vector from jump, multi-requester stall, and JTAG halt inputs. Jump flush can span several cycles, and JTAG halt uses a drain-then-acknowledge handshake. It sits beside the pipeline registers of the CPU core and feeds every stage register's hold and flush inputs.

---
 rtl/ppl_ctrl_pkg.sv | 32 +++
 rtl/ppl_ctrl_hold_mask.sv | 32 +++
 rtl/ppl_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ppl_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppl_ctrl_pkg.sv
// ============================================================================
// Module   : ppl_ctrl_pkg
// Brief    : State encodings, default geometry and width helpers for ppl_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppl_ctrl_pkg;

    localparam logic [1:0] PPL_RUN   = 2'd0;
    localparam logic [1:0] PPL_FLUSH = 2'd1;
    localparam logic [1:0] PPL_DRAIN = 2'd2;
    localparam logic [1:0] PPL_HALT  = 2'd3;

    localparam int PPL_STAGES_DEF   = 4;
    localparam int PPL_EX_STAGE_DEF = 3;

    // Width of one packed req_stage field.
    function automatic int ppl_sw(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    // Counter must hold both FLUSH_LEN-1 and STAGES-2 without wrapping.
    function automatic int ppl_cw(input int flen, input int stages);
        int m;
        m = (flen > stages) ? flen : stages;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ppl_ctrl_hold_mask.sv
// ============================================================================
// Module   : ppl_hold_mask
// Brief    : Reduces per-requester stall levels to a thermometer hold mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppl_hold_mask #(
    parameter int STAGES = 4,
    parameter int NREQ   = 2,
    parameter int SW     = 2
) (
    input  logic [NREQ-1:0]    hold_req,
    input  logic [NREQ*SW-1:0] req_stage,
    output logic [STAGES-1:0]  mask
);

    always_comb begin
        mask    = '0;
        mask[0] = |hold_req;
        for (int i = 1; i < STAGES; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (hold_req[r] && (req_stage[r*SW +: SW] >= SW'(i))) begin
                    mask[i] = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ppl_ctrl.sv
// ============================================================================
// Module   : ppl_ctrl
// Brief    : Per-stage hold/flush generator with jump flush, multi-requester
//            stall and JTAG drain-then-ack halt. PPL_CTRL_PERF_EN adds the
//            stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppl_ctrl
    import ppl_ctrl_pkg::*;
#(
    parameter int STAGES    = PPL_STAGES_DEF,
    parameter int EX_STAGE  = PPL_EX_STAGE_DEF,
    parameter int NREQ      = 2,
    parameter int FLUSH_LEN = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              jump_flag,
    input  logic [NREQ-1:0]                   hold_req,
    input  logic [NREQ*ppl_sw(STAGES)-1:0]    req_stage,
    input  logic                              jtag_halt_req,
    output logic                              jtag_halt_ack,
    output logic [STAGES-1:0]                 hold,
    output logic [STAGES-1:0]                 flush
`ifdef PPL_CTRL_PERF_EN
    ,
    output logic [31:0]                       stall_cycles
`endif
);

    localparam int SW = ppl_sw(STAGES);
    localparam int CW = ppl_cw(FLUSH_LEN, STAGES);

    localparam logic [CW-1:0] c_flush_reload = CW'(FLUSH_LEN - 1);
    localparam logic [CW-1:0] c_drain_last   = CW'(STAGES - 2);
    localparam logic [SW-1:0] c_ex_stage     = SW'(EX_STAGE);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [STAGES-1:0] w_mask;
    logic [STAGES-1:0] w_jmp_flush;
    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_flush;
    logic              w_any_req;
    logic              w_ex_stall;
    logic              w_jump;

    ppl_hold_mask #(
        .STAGES (STAGES),
        .NREQ   (NREQ),
        .SW     (SW)
    ) u_hold_mask (
        .hold_req  (hold_req),
        .req_stage (req_stage),
        .mask      (w_mask)
    );

    // A stall reaching the EX stage freezes the jumping instruction, so the jump waits.
    always_comb begin
        w_ex_stall = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (hold_req[r] && (req_stage[r*SW +: SW] >= c_ex_stage)) begin
                w_ex_stall = 1'b1;
            end
        end
    end

    assign w_any_req = |hold_req;
    assign w_jump    = jump_flag & ~w_ex_stall;

    always_comb begin
        w_jmp_flush = '0;
        for (int i = 1; i < STAGES; i++) begin
            if (i <= EX_STAGE) begin
                w_jmp_flush[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold      = w_mask;
        w_flush     = '0;

        case (r_state)
            PPL_RUN: begin
                if (w_jump) begin
                    w_flush   = w_jmp_flush;
                    w_hold[0] = 1'b0;
                    if (FLUSH_LEN > 1) begin
                        w_state_nxt = PPL_FLUSH;
                        w_cnt_nxt   = c_flush_reload;
                    end
                end else if (jtag_halt_req && !jump_flag && !w_any_req) begin
                    w_state_nxt = PPL_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end

            PPL_FLUSH: begin
                w_flush   = w_jmp_flush;
                w_hold[0] = 1'b0;
                if (w_jump) begin
                    w_cnt_nxt = c_flush_reload;
                end else if (r_cnt <= CW'(1)) begin
                    w_state_nxt = PPL_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            PPL_DRAIN: begin
                if (!jtag_halt_req) begin
                    // Abandoned halt behaves like an ordinary RUN cycle.
                    w_state_nxt = PPL_RUN;
                    w_cnt_nxt   = '0;
                    if (w_jump) begin
                        w_flush   = w_jmp_flush;
                        w_hold[0] = 1'b0;
                        if (FLUSH_LEN > 1) begin
                            w_state_nxt = PPL_FLUSH;
                            w_cnt_nxt   = c_flush_reload;
                        end
                    end
                end else if (w_jump) begin
                    w_flush   = w_jmp_flush;
                    w_hold[0] = 1'b0;
                    w_cnt_nxt = '0;
                end else begin
                    w_hold[0]  = 1'b1;
                    w_flush[1] = 1'b1;
                    if (!w_any_req) begin
                        if (r_cnt >= c_drain_last) begin
                            w_state_nxt = PPL_HALT;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
            end

            default: begin
                w_hold = '1;
                if (!jtag_halt_req) begin
                    w_state_nxt = PPL_RUN;
                    w_cnt_nxt   = '0;
                end
            end
        endcase

        w_hold = w_hold & ~w_flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PPL_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are forced low for the whole reset window, not just the state.
    assign hold          = rst_n ? w_hold  : '0;
    assign flush         = rst_n ? w_flush : '0;
    assign jtag_halt_ack = (r_state == PPL_HALT);

`ifdef PPL_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if ((r_state != PPL_HALT) && (w_hold[0] || (|w_flush))) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ppl_ctrl.sv
// ============================================================================
// Module   : tb_ppl_ctrl
// Brief    : Scoreboard bench for ppl_ctrl (STAGES=4, EX_STAGE=3, NREQ=2,
//            FLUSH_LEN=2) with directed, hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppl_ctrl;

    logic       clk;
    logic       rst_n;
    logic       jump_flag;
    logic [1:0] hold_req;
    logic [3:0] req_stage;
    logic       jtag_halt_req;
    logic       jtag_halt_ack;
    logic [3:0] hold;
    logic [3:0] flush;
`ifdef PPL_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    ppl_ctrl #(
        .STAGES    (4),
        .EX_STAGE  (3),
        .NREQ      (2),
        .FLUSH_LEN (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump_flag     (jump_flag),
        .hold_req      (hold_req),
        .req_stage     (req_stage),
        .jtag_halt_req (jtag_halt_req),
        .jtag_halt_ack (jtag_halt_ack),
        .hold          (hold),
        .flush         (flush)
`ifdef PPL_CTRL_PERF_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       q_cyc[$];
    logic [3:0] q_hold[$];
    logic [3:0] q_flush[$];
    logic     q_ack[$];
    string    q_name[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input logic [3:0] h, input logic [3:0] f, input logic a, input string nm);
        q_cyc.push_back(cyc);
        q_hold.push_back(h);
        q_flush.push_back(f);
        q_ack.push_back(a);
        q_name.push_back(nm);
    endtask

    // Monitor: compares every expectation scheduled for the current cycle.
    always @(negedge clk) begin : mon
        int         ec;
        logic [3:0] eh;
        logic [3:0] ef;
        logic       ea;
        string      en;
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            ec = q_cyc.pop_front();
            eh = q_hold.pop_front();
            ef = q_flush.pop_front();
            ea = q_ack.pop_front();
            en = q_name.pop_front();
            n_vec++;
            if (ec != cyc || hold !== eh || flush !== ef || jtag_halt_ack !== ea) begin
                n_err++;
                $display("FAIL %s: got hold=%b flush=%b ack=%b, expected hold=%b flush=%b ack=%b (cycle %0d/%0d)",
                         en, hold, flush, jtag_halt_ack, eh, ef, ea, cyc, ec);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        jump_flag     = 1'b0;
        hold_req      = 2'b00;
        req_stage     = 4'b0000;
        jtag_halt_req = 1'b0;

        // Reset: outputs gated low even with an active requester.
        tick();
        exp_out(4'b0000, 4'b0000, 1'b0, "rst_idle");
        tick();
        hold_req = 2'b01; req_stage = {2'd0, 2'd3};
        exp_out(4'b0000, 4'b0000, 1'b0, "rst_gate");
        tick();
        rst_n = 1'b1; hold_req = 2'b00; req_stage = 4'b0000;
        exp_out(4'b0000, 4'b0000, 1'b0, "run_idle");

        // Stall masks
        tick();
        hold_req = 2'b10; req_stage = {2'd1, 2'd0};
        exp_out(4'b0011, 4'b0000, 1'b0, "stall_r1_s1");
        tick();
        hold_req = 2'b11; req_stage = {2'd0, 2'd2};
        exp_out(4'b0111, 4'b0000, 1'b0, "stall_two_req");
        tick();
        hold_req = 2'b01; req_stage = {2'd3, 2'd0};
        exp_out(4'b0001, 4'b0000, 1'b0, "stall_r0_s0");

        // Single-cycle jump: two flush cycles
        tick();
        hold_req = 2'b00; req_stage = 4'b0000; jump_flag = 1'b1;
        exp_out(4'b0000, 4'b1110, 1'b0, "jmp_c0");
        tick();
        jump_flag = 1'b0;
        exp_out(4'b0000, 4'b1110, 1'b0, "jmp_c1");
        tick();
        exp_out(4'b0000, 4'b0000, 1'b0, "jmp_end");

        // Jump blocked by an EX-level stall, taken when it drops
        tick();
        jump_flag = 1'b1; hold_req = 2'b01; req_stage = {2'd0, 2'd3};
        exp_out(4'b1111, 4'b0000, 1'b0, "jmp_vs_ex_a");
        tick();
        exp_out(4'b1111, 4'b0000, 1'b0, "jmp_vs_ex_b");
        tick();
        hold_req = 2'b00;
        exp_out(4'b0000, 4'b1110, 1'b0, "jmp_released");
        tick();
        jump_flag = 1'b0;
        exp_out(4'b0000, 4'b1110, 1'b0, "jmp_released_c1");
        tick();
        exp_out(4'b0000, 4'b0000, 1'b0, "jmp_released_end");

        // Jump beats a low-stage stall
        tick();
        jump_flag = 1'b1; hold_req = 2'b10; req_stage = {2'd1, 2'd0};
        exp_out(4'b0000, 4'b1110, 1'b0, "jmp_vs_low");
        tick();
        jump_flag = 1'b0;
        exp_out(4'b0000, 4'b1110, 1'b0, "jmp_vs_low_c1");
        tick();
        hold_req = 2'b00; req_stage = 4'b0000;
        exp_out(4'b0000, 4'b0000, 1'b0, "jmp_vs_low_end");

        // Halt handshake
        tick();
        jtag_halt_req = 1'b1;
        exp_out(4'b0000, 4'b0000, 1'b0, "halt_sample");
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_out(4'b0001, 4'b0010, 1'b0, $sformatf("drain_%0d", i));
        end
        tick();
        exp_out(4'b1111, 4'b0000, 1'b1, "halted");
        tick();
        jump_flag = 1'b1; hold_req = 2'b10; req_stage = {2'd1, 2'd0};
        exp_out(4'b1111, 4'b0000, 1'b1, "halt_ignore");
        tick();
        jump_flag = 1'b0; hold_req = 2'b00; req_stage = 4'b0000; jtag_halt_req = 1'b0;
        exp_out(4'b1111, 4'b0000, 1'b1, "halt_release");
        tick();
        exp_out(4'b0000, 4'b0000, 1'b0, "resumed");

        // Halt during FLUSH waits; a stalled drain cycle delays ack by one
        tick();
        jump_flag = 1'b1;
        exp_out(4'b0000, 4'b1110, 1'b0, "hf_jump");
        tick();
        jump_flag = 1'b0; jtag_halt_req = 1'b1;
        exp_out(4'b0000, 4'b1110, 1'b0, "hf_flush");
        tick();
        exp_out(4'b0000, 4'b0000, 1'b0, "hf_run_sample");
        tick();
        exp_out(4'b0001, 4'b0010, 1'b0, "hf_drain0");
        tick();
        hold_req = 2'b01; req_stage = {2'd0, 2'd2};
        exp_out(4'b0101, 4'b0010, 1'b0, "hf_drain_stall");
        tick();
        hold_req = 2'b00; req_stage = 4'b0000;
        exp_out(4'b0001, 4'b0010, 1'b0, "hf_drain1");
        tick();
        exp_out(4'b0001, 4'b0010, 1'b0, "hf_drain2_no_ack");
        tick();
        exp_out(4'b1111, 4'b0000, 1'b1, "hf_halted");
        tick();
        jtag_halt_req = 1'b0;
        exp_out(4'b1111, 4'b0000, 1'b1, "hf_release");
        tick();
        exp_out(4'b0000, 4'b0000, 1'b0, "hf_resumed");

        // Asynchronous reset in the middle of DRAIN
        tick();
        jtag_halt_req = 1'b1;
        exp_out(4'b0000, 4'b0000, 1'b0, "rd_sample");
        tick();
        exp_out(4'b0001, 4'b0010, 1'b0, "rd_drain0");
        tick();
        rst_n = 1'b0;
        exp_out(4'b0000, 4'b0000, 1'b0, "rst_mid_drain");
        tick();
        rst_n = 1'b1;
        exp_out(4'b0000, 4'b0000, 1'b0, "rst_after_run");
        tick();
        exp_out(4'b0001, 4'b0010, 1'b0, "rd_redrain0");
        tick();
        jtag_halt_req = 1'b0;
        exp_out(4'b0000, 4'b0000, 1'b0, "drain_abort");
        tick();
        exp_out(4'b0000, 4'b0000, 1'b0, "abort_run");

        tick();
        @(negedge clk);
        #1;
        if (q_cyc.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q_cyc.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
